// File: rtl/acorn128_pkg.sv
// rtl/acorn128_pkg.sv - shared constants, FSM encoding and boolean helpers for ACORN-128
package acorn128_pkg;

    localparam int STATE_W = 293;

    localparam int T0   = 0;
    localparam int T12  = 12;
    localparam int T23  = 23;
    localparam int T61  = 61;
    localparam int T66  = 66;
    localparam int T107 = 107;
    localparam int T111 = 111;
    localparam int T154 = 154;
    localparam int T160 = 160;
    localparam int T193 = 193;
    localparam int T196 = 196;
    localparam int T230 = 230;
    localparam int T235 = 235;
    localparam int T244 = 244;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_C,
        ST_SHIFT,
        ST_OUT,
        ST_FIN
    } fsm_e;

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic ch(input logic x, input logic y, input logic z);
        return (x & y) ^ (~x & z);
    endfunction

endpackage

// File: rtl/acorn128_dec_step.sv
// rtl/acorn128_dec_step.sv - one combinational decrypt step: recover a plaintext bit and advance the state
module acorn128_dec_step
    import acorn128_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic               c_bit_i,
    input  logic               ca_i,
    input  logic               cb_i,
    output logic [STATE_W-1:0] next_state_o,
    output logic               p_bit_o
);

    logic [STATE_W-1:0] s;
    logic               ks;
    logic               f;

    // Each LFSR segment folds in values taken before the next lower segment is touched.
    always_comb begin
        s       = state_i;
        s[289]  = s[289]  ^ s[T235] ^ s[T230];
        s[T230] = s[T230] ^ s[T196] ^ s[T193];
        s[T193] = s[T193] ^ s[T160] ^ s[T154];
        s[T154] = s[T154] ^ s[T111] ^ s[T107];
        s[T107] = s[T107] ^ s[T66]  ^ s[T61];
        s[T61]  = s[T61]  ^ s[T23]  ^ s[T0];
    end

    ksg128 u_ksg (
        .s12_i  (s[T12]),
        .s154_i (s[T154]),
        .s235_i (s[T235]),
        .s61_i  (s[T61]),
        .s193_i (s[T193]),
        .s230_i (s[T230]),
        .s111_i (s[T111]),
        .s66_i  (s[T66]),
        .ks_o   (ks)
    );

    fbk128 u_fbk (
        .s0_i   (s[T0]),
        .s107_i (s[T107]),
        .s244_i (s[T244]),
        .s23_i  (s[T23]),
        .s160_i (s[T160]),
        .s196_i (s[T196]),
        .ks_i   (ks),
        .ca_i   (ca_i),
        .cb_i   (cb_i),
        .f_o    (f)
    );

    assign p_bit_o      = c_bit_i ^ ks;
    assign next_state_o = {f ^ p_bit_o, s[STATE_W-1:1]};

endmodule

// File: rtl/fbk128.sv
// rtl/fbk128.sv - ACORN-128 nonlinear feedback bit from the linearly updated state
module fbk128
    import acorn128_pkg::*;
(
    input  logic s0_i,
    input  logic s107_i,
    input  logic s244_i,
    input  logic s23_i,
    input  logic s160_i,
    input  logic s196_i,
    input  logic ks_i,
    input  logic ca_i,
    input  logic cb_i,
    output logic f_o
);

    assign f_o = s0_i ^ (~s107_i) ^ maj(s244_i, s23_i, s160_i) ^ (ca_i & s196_i) ^ (cb_i & ks_i);

endmodule

// File: rtl/ksg128.sv
// rtl/ksg128.sv - ACORN-128 keystream bit from the linearly updated state
module ksg128
    import acorn128_pkg::*;
(
    input  logic s12_i,
    input  logic s154_i,
    input  logic s235_i,
    input  logic s61_i,
    input  logic s193_i,
    input  logic s230_i,
    input  logic s111_i,
    input  logic s66_i,
    output logic ks_o
);

    assign ks_o = s12_i ^ s154_i ^ maj(s235_i, s61_i, s193_i) ^ ch(s230_i, s111_i, s66_i);

endmodule

// File: rtl/acorn128_decrypt_core.sv
// rtl/acorn128_decrypt_core.sv - bit-serial ACORN-128 decryption: byte handshakes around one step per cycle
module acorn128_decrypt_core
    import acorn128_pkg::*;
#(
    parameter logic CA_MSG = 1'b1,
    parameter logic CB_MSG = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [STATE_W-1:0] state_in,
    input  logic               c_valid,
    output logic               c_ready,
    input  logic [7:0]         c_data,
    input  logic               c_last,
    output logic               p_valid,
    input  logic               p_ready,
    output logic [7:0]         p_data,
    output logic               p_last,
    output logic               done,
    output logic [STATE_W-1:0] state_out
);

    fsm_e               fsm_q;
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [7:0]         c_data_q;
    logic               c_last_q;
    logic [7:0]         p_data_q;
    logic [2:0]         cnt_q;
    logic               p_bit_d;

    acorn128_dec_step u_step (
        .state_i      (state_q),
        .c_bit_i      (c_data_q[cnt_q]),
        .ca_i         (CA_MSG),
        .cb_i         (CB_MSG),
        .next_state_o (state_d),
        .p_bit_o      (p_bit_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            state_q  <= '0;
            c_data_q <= '0;
            c_last_q <= 1'b0;
            p_data_q <= '0;
            cnt_q    <= '0;
        end else begin
            case (fsm_q)
                ST_IDLE: if (load_valid) begin
                    state_q <= state_in;
                    fsm_q   <= ST_WAIT_C;
                end
                ST_WAIT_C: if (c_valid) begin
                    c_data_q <= c_data;
                    c_last_q <= c_last;
                    cnt_q    <= '0;
                    fsm_q    <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    state_q         <= state_d;
                    p_data_q[cnt_q] <= p_bit_d;
                    // Counter rolls 7->0 on the same edge that leaves SHIFT.
                    cnt_q           <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) fsm_q <= ST_OUT;
                end
                ST_OUT: if (p_ready) fsm_q <= c_last_q ? ST_FIN : ST_WAIT_C;
                ST_FIN:  fsm_q <= ST_IDLE;
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign load_ready = (fsm_q == ST_IDLE);
    assign c_ready    = (fsm_q == ST_WAIT_C);
    assign p_valid    = (fsm_q == ST_OUT);
    assign p_last     = (fsm_q == ST_OUT) & c_last_q;
    assign done       = (fsm_q == ST_FIN);
    assign p_data     = p_data_q;
    assign state_out  = state_q;

endmodule

// File: tb/tb_acorn128_decrypt_core.sv
// tb/tb_acorn128_decrypt_core.sv - directed scoreboard bench for acorn128_decrypt_core
module tb_acorn128_decrypt_core;

    localparam logic CA = 1'b1;
    localparam logic CB = 1'b0;
    typedef logic [292:0] w_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load_valid = 1'b0;
    logic         c_valid = 1'b0;
    logic         c_last = 1'b0;
    logic         p_ready = 1'b0;
    logic [7:0]   c_data = 8'h00;
    logic [292:0] state_in = '0;
    logic         load_ready, c_ready, p_valid, p_last, done;
    logic [7:0]   p_data;
    logic [292:0] state_out;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    acorn128_decrypt_core #(.CA_MSG(CA), .CB_MSG(CB)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .state_in   (state_in),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .c_data     (c_data),
        .c_last     (c_last),
        .p_valid    (p_valid),
        .p_ready    (p_ready),
        .p_data     (p_data),
        .p_last     (p_last),
        .done       (done),
        .state_out  (state_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input w_t obs, input w_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic mj(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Reference encryptor: the ciphertext it emits must decrypt back to p.
    function automatic w_t enc_byte(input w_t s_in, input logic [7:0] p, output logic [7:0] c);
        w_t   s;
        logic k, f;
        s = s_in;
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            s[289] = s[289] ^ s[235] ^ s[230];
            s[230] = s[230] ^ s[196] ^ s[193];
            s[193] = s[193] ^ s[160] ^ s[154];
            s[154] = s[154] ^ s[111] ^ s[107];
            s[107] = s[107] ^ s[66] ^ s[61];
            s[61]  = s[61] ^ s[23] ^ s[0];
            k = s[12] ^ s[154] ^ mj(s[235], s[61], s[193]) ^ (s[230] ? s[111] : s[66]);
            f = s[0] ^ (~s[107]) ^ mj(s[244], s[23], s[160]) ^ (CA & s[196]) ^ (CB & k);
            c[i] = p[i] ^ k;
            s = {f ^ p[i], s[292:1]};
        end
        return s;
    endfunction

    task automatic load(input w_t s, input string tag);
        int t = 0;
        load_valid = 1'b1;
        state_in   = s;
        while (!load_ready && t < 40) begin tick(); t++; end
        chk({tag, "_load_ready"}, w_t'(load_ready), w_t'(1'b1));
        tick();
        load_valid = 1'b0;
        chk({tag, "_c_ready_after_load"}, w_t'(c_ready), w_t'(1'b1));
    endtask

    task automatic send(input logic [7:0] c, input logic last, input string tag);
        int t = 0;
        c_valid = 1'b1;
        c_data  = c;
        c_last  = last;
        while (!c_ready && t < 40) begin tick(); t++; end
        chk({tag, "_c_ready"}, w_t'(c_ready), w_t'(1'b1));
        tick();
        c_valid = 1'b0;
    endtask

    task automatic wait_p(input string tag);
        int lat = 1;
        while (!p_valid && lat < 40) begin tick(); lat++; end
        chk({tag, "_latency"}, w_t'(lat), w_t'(9));
    endtask

    task automatic recv(input string tag);
        logic [8:0] e;
        int t = 0;
        while (!p_valid && t < 40) begin tick(); t++; end
        chk({tag, "_p_valid"}, w_t'(p_valid), w_t'(1'b1));
        if (sb.size() == 0) begin
            chk({tag, "_sb_underflow"}, w_t'(sb.size()), w_t'(1));
        end else begin
            e = sb.pop_front();
            chk({tag, "_p_data"}, w_t'(p_data), w_t'(e[7:0]));
            chk({tag, "_p_last"}, w_t'(p_last), w_t'(e[8]));
        end
        p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
    endtask

    task automatic zero_a5(input string tag);
        load('0, tag);
        sb.push_back({1'b1, 8'hA5});
        send(8'hA5, 1'b1, tag);
        wait_p(tag);
        recv(tag);
        chk({tag, "_done"}, w_t'(done), w_t'(1'b1));
        chk({tag, "_state_out"}, state_out, {8'h5A, 285'b0});
        tick();
        chk({tag, "_done_pulse"}, w_t'(done), w_t'(1'b0));
        chk({tag, "_idle"}, w_t'(load_ready), w_t'(1'b1));
    endtask

    initial begin
        w_t         rs;
        w_t         mst[16];
        logic [7:0] pt[16];
        logic [7:0] ct[16];
        logic [319:0] wide;

        repeat (3) tick();
        chk("rst_load_ready", w_t'(load_ready), w_t'(1'b1));
        chk("rst_c_ready", w_t'(c_ready), w_t'(1'b0));
        chk("rst_p_valid", w_t'(p_valid), w_t'(1'b0));
        chk("rst_p_last", w_t'(p_last), w_t'(1'b0));
        chk("rst_p_data", w_t'(p_data), w_t'(8'h00));
        chk("rst_done", w_t'(done), w_t'(1'b0));
        chk("rst_state_out", state_out, '0);
        rst = 1'b0;
        tick();

        zero_a5("zero");

        for (int i = 0; i < 10; i++) wide[i*32 +: 32] = $urandom;
        rs = wide[292:0];
        mst[0] = rs;
        for (int k = 0; k < 16; k++) begin
            pt[k]  = 8'($urandom);
            mst[k] = enc_byte((k == 0) ? rs : mst[k-1], pt[k], ct[k]);
        end
        load(rs, "rt");
        for (int k = 0; k < 16; k++) begin
            sb.push_back({k == 15, pt[k]});
            send(ct[k], k == 15, "rt");
            if (k == 5) begin
                wait_p("bp");
                for (int j = 0; j < 5; j++) begin
                    tick();
                    chk("bp_p_data", w_t'(p_data), w_t'(pt[5]));
                    chk("bp_c_ready", w_t'(c_ready), w_t'(1'b0));
                    chk("bp_state", state_out, mst[5]);
                end
            end
            recv("rt");
        end
        chk("rt_done", w_t'(done), w_t'(1'b1));
        chk("rt_final_state", state_out, mst[15]);
        tick();

        load('0, "rstmid");
        send(8'hA5, 1'b1, "rstmid");
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rstmid_load_ready", w_t'(load_ready), w_t'(1'b1));
        chk("rstmid_p_valid", w_t'(p_valid), w_t'(1'b0));
        chk("rstmid_state_out", state_out, '0);
        chk("rstmid_p_data", w_t'(p_data), w_t'(8'h00));
        rst = 1'b0;
        tick();
        zero_a5("after_rst");

        c_valid = 1'b1;
        c_data  = 8'h33;
        c_last  = 1'b0;
        repeat (3) begin
            tick();
            chk("mis_idle_c_ready", w_t'(c_ready), w_t'(1'b0));
        end
        c_valid = 1'b0;
        load('0, "mis");
        load_valid = 1'b1;
        state_in   = '1;
        repeat (2) begin
            tick();
            chk("mis_wait_load_ready", w_t'(load_ready), w_t'(1'b0));
        end
        load_valid = 1'b0;
        sb.push_back({1'b1, 8'hA5});
        send(8'hA5, 1'b1, "mis");
        wait_p("mis");
        c_valid = 1'b1;
        c_data  = 8'h33;
        repeat (3) begin
            tick();
            chk("mis_out_c_ready", w_t'(c_ready), w_t'(1'b0));
        end
        c_valid = 1'b0;
        recv("mis");
        chk("mis_done", w_t'(done), w_t'(1'b1));
        chk("mis_state_out", state_out, {8'h5A, 285'b0});
        tick();
        chk("sb_empty", w_t'(sb.size()), w_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
